// File: rtl/shift_add_multiplier.sv
// Multi-cycle shift-and-add multiplier, one partial product per clock.
// Signed mode multiplies magnitudes and negates the result at the end, so
// the core loop is always an unsigned W x W -> 2W accumulate.
module shift_add_multiplier #(
  parameter int p_data_width = 4
) (
  input  logic                        i_w_clk,
  input  logic                        i_w_reset,
  input  logic [p_data_width-1:0]     i_w_a,
  input  logic [p_data_width-1:0]     i_w_b,
  input  logic                        i_w_signed,
  input  logic                        i_w_start,
  output logic                        o_w_busy,
  output logic                        o_w_done,
  output logic [2*p_data_width-1:0]   o_w_out,
  output logic [p_data_width-1:0]     o_w_disp_a,
  output logic [p_data_width-1:0]     o_w_disp_b
);

  localparam int W  = p_data_width;
  // Counter must hold W (its value after the last iteration).
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);
  localparam logic [CW-1:0]  ONE_C = CW'(1);
  localparam logic [W-1:0]   ONE_W = W'(1);
  localparam logic [2*W-1:0] ONE_P = {{(2*W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  mcand_q, acc_q, acc_sum;
  logic [W-1:0]    mplier_q, abs_a, abs_b;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic            accept, last_iter;

  assign accept    = (state_q == S_IDLE) && i_w_start;
  assign last_iter = (cnt_q == LAST);

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is still correct read unsigned.
  assign abs_a = (i_w_signed && i_w_a[W-1]) ? (~i_w_a + ONE_W) : i_w_a;
  assign abs_b = (i_w_signed && i_w_b[W-1]) ? (~i_w_b + ONE_W) : i_w_b;

  // Accumulator including the current partial product; also feeds the final result.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // State register.
  always_ff @(posedge i_w_clk) begin
    if (!i_w_reset) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next state and Moore outputs decoded from the registered state.
  always_comb begin
    state_d  = state_q;
    o_w_busy = 1'b0;
    o_w_done = 1'b0;
    case (state_q)
      S_IDLE: if (i_w_start) state_d = S_RUN;
      S_RUN: begin
        o_w_busy = 1'b1;
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        o_w_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, one shift-add step per RUN cycle, result on the last step.
  always_ff @(posedge i_w_clk) begin
    if (!i_w_reset) begin
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      o_w_out    <= '0;
      o_w_disp_a <= '0;
      o_w_disp_b <= '0;
    end else if (accept) begin
      o_w_disp_a <= i_w_a;
      o_w_disp_b <= i_w_b;
      neg_q      <= i_w_signed & (i_w_a[W-1] ^ i_w_b[W-1]);
      mcand_q    <= {{W{1'b0}}, abs_a};
      mplier_q   <= abs_b;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else if (state_q == S_RUN) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + ONE_C;
      if (last_iter)
        o_w_out <= neg_q ? (~acc_sum + ONE_P) : acc_sum;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: W=4 and W=8 instances, a cycle-level
// behavioural model checked every cycle, plus literal products per test.
module tb_shift_add_multiplier;

  localparam int W4 = 4;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a4 = '0, b4 = '0, da4, db4;
  logic        s4 = 1'b0, st4 = 1'b0, busy4, done4;
  logic [7:0]  out4;
  logic [7:0]  a8 = '0, b8 = '0, da8, db8;
  logic        s8 = 1'b0, st8 = 1'b0, busy8, done8;
  logic [15:0] out8;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.p_data_width(W4)) u_dut4 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_a(a4), .i_w_b(b4), .i_w_signed(s4),
    .i_w_start(st4), .o_w_busy(busy4), .o_w_done(done4), .o_w_out(out4),
    .o_w_disp_a(da4), .o_w_disp_b(db4));

  shift_add_multiplier #(.p_data_width(W8)) u_dut8 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_a(a8), .i_w_b(b8), .i_w_signed(s8),
    .i_w_start(st8), .o_w_busy(busy8), .o_w_done(done8), .o_w_out(out8),
    .o_w_disp_a(da8), .o_w_disp_b(db8));

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Plain integer product, reduced mod 2^(2w).
  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b,
                                       input logic s, input int w);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    return 16'(p);
  endfunction

  // Model: phase 0 idle, 1..W busy, W+1 done; product computed at accept.
  int          m4_ph = 0, m8_ph = 0;
  logic [7:0]  m4_out = '0, m4_pend = '0;
  logic [3:0]  m4_da = '0, m4_db = '0;
  logic [15:0] m8_out = '0, m8_pend = '0;
  logic [7:0]  m8_da = '0, m8_db = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m4_ph <= 0; m4_out <= '0; m4_da <= '0; m4_db <= '0;
      m8_ph <= 0; m8_out <= '0; m8_da <= '0; m8_db <= '0;
    end else begin
      if (m4_ph == 0) begin
        if (st4) begin
          m4_ph <= 1; m4_da <= a4; m4_db <= b4;
          m4_pend <= 8'(prod(8'(a4), 8'(b4), s4, W4));
        end
      end else if (m4_ph == W4) begin
        m4_out <= m4_pend; m4_ph <= W4 + 1;
      end else if (m4_ph == W4 + 1) m4_ph <= 0;
      else m4_ph <= m4_ph + 1;

      if (m8_ph == 0) begin
        if (st8) begin
          m8_ph <= 1; m8_da <= a8; m8_db <= b8;
          m8_pend <= prod(a8, b8, s8, W8);
        end
      end else if (m8_ph == W8) begin
        m8_out <= m8_pend; m8_ph <= W8 + 1;
      end else if (m8_ph == W8 + 1) m8_ph <= 0;
      else m8_ph <= m8_ph + 1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("busy4", 16'(busy4), 16'(m4_ph >= 1 && m4_ph <= W4));
    check("done4", 16'(done4), 16'(m4_ph == W4 + 1));
    check("out4",  16'(out4),  16'(m4_out));
    check("disp_a4", 16'(da4), 16'(m4_da));
    check("disp_b4", 16'(db4), 16'(m4_db));
    check("busy8", 16'(busy8), 16'(m8_ph >= 1 && m8_ph <= W8));
    check("done8", 16'(done8), 16'(m8_ph == W8 + 1));
    check("out8",  out8,       m8_out);
    check("disp_a8", 16'(da8), 16'(m8_da));
    check("disp_b8", 16'(db8), 16'(m8_db));
  end

  // One W=4 operation with a literal expected product and busy length.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     input logic [7:0] exp, input string nm);
    int   busy_n;
    logic got;
    busy_n = 0;
    got    = 1'b0;
    @(negedge clk);
    a4 = a; b4 = b; s4 = s; st4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      st4 = 1'b0;
      if (done4) begin got = 1'b1; break; end
      if (busy4) busy_n++;
    end
    check({nm, "_done_seen"}, 16'(got), 16'd1);
    check({nm, "_busy_cycles"}, 16'(busy_n), 16'(W4));
    check({nm, "_out"}, 16'(out4), 16'(exp));
    check({nm, "_disp_a"}, 16'(da4), 16'(a));
    check({nm, "_disp_b"}, 16'(db4), 16'(b));
  endtask

  initial begin
    int nd, t1, t2;
    logic got;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out4", 16'(out4), 16'h0);
    check("rst_busy4", 16'(busy4), 16'h0);
    check("rst_done4", 16'(done4), 16'h0);
    check("rst_out8", out8, 16'h0);
    rst = 1'b1;

    // Model pins.
    check("model_uns", prod(8'hF, 8'hF, 1'b0, 4), 16'hE1);
    check("model_sgn", prod(8'hD, 8'h5, 1'b1, 4), 16'hF1);
    check("model_w8",  prod(8'h80, 8'h80, 1'b1, 8), 16'h4000);

    // Unsigned max and signed corners.
    op4(4'hF, 4'hF, 1'b0, 8'hE1, "umax");
    op4(4'h8, 4'h8, 1'b1, 8'h40, "s_8x8");
    op4(4'hD, 4'h5, 1'b1, 8'hF1, "s_m3x5");
    op4(4'h7, 4'h8, 1'b1, 8'hC8, "s_7xm8");
    op4(4'h0, 4'h8, 1'b1, 8'h00, "s_0xm8");

    // Starts during RUN and DONE are ignored.
    nd = 0;
    got = 1'b0;
    @(negedge clk); a4 = 4'h3; b4 = 4'h5; s4 = 1'b0; st4 = 1'b1;
    @(negedge clk); st4 = 1'b0;
    @(negedge clk); a4 = 4'h9; b4 = 4'h9; st4 = 1'b1;
    @(negedge clk); st4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done4) begin got = 1'b1; nd++; break; end
    end
    check("ign_done_seen", 16'(got), 16'd1);
    st4 = 1'b1;
    @(negedge clk); st4 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done4) nd++;
    end
    check("ign_done_count", 16'(nd), 16'd1);
    check("ign_out", 16'(out4), 16'h0F);
    check("ign_disp_a", 16'(da4), 16'h3);
    check("ign_disp_b", 16'(db4), 16'h5);

    // Reset on the second RUN cycle aborts.
    @(negedge clk); a4 = 4'h7; b4 = 4'h7; s4 = 1'b0; st4 = 1'b1;
    @(negedge clk); st4 = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("abort_out", 16'(out4), 16'h0);
    check("abort_busy", 16'(busy4), 16'h0);
    check("abort_done", 16'(done4), 16'h0);
    check("abort_disp_a", 16'(da4), 16'h0);
    rst = 1'b1;
    op4(4'h2, 4'h3, 1'b0, 8'h06, "post_rst");

    // Result hold with toggling inputs.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a4 = 4'($urandom); b4 = 4'($urandom); s4 = ~s4;
      check("hold_out", 16'(out4), 16'h06);
      check("hold_disp_a", 16'(da4), 16'h2);
      check("hold_disp_b", 16'(db4), 16'h3);
      check("hold_busy", 16'(busy4), 16'h0);
      check("hold_done", 16'(done4), 16'h0);
    end

    // Back-to-back, W=8, start held high.
    nd = 0; t1 = -1; t2 = -1;
    @(negedge clk); a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; st8 = 1'b1;
    @(negedge clk); a8 = 8'h80; b8 = 8'h80; s8 = 1'b1;
    for (int i = 1; i < 40; i++) begin
      if (done8) begin
        nd++;
        if (nd == 1) begin t1 = i; check("b2b_out1", out8, 16'hFE01); end
        else begin
          t2 = i; check("b2b_out2", out8, 16'h4000);
          st8 = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    check("b2b_done_count", 16'(nd), 16'd2);
    check("b2b_spacing", 16'(t2 - t1), 16'(W8 + 2));
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised, multi-cycle shift-and-add multiplier. It is the successor to the single-cycle register/FSM multiplier and sits in the same datapath slot. It captures two `p_data_width`-bit operands on a start pulse and iterates one partial product per clock. It supports unsigned and two's-complement modes, reports progress with a busy/done handshake, and holds the last product and operands for display.

## Interface
- `p_data_width`, default 4: operand width W; legal values W ≥ 2. Product width is 2W.
- `i_w_clk` in, 1: single clock; all state updates on its rising edge.
- `i_w_reset` in, 1: synchronous, active-low reset.
- `i_w_a` in, W: multiplicand; sampled only on an accepted start.
- `i_w_b` in, W: multiplier; sampled only on an accepted start.
- `i_w_signed` in, 1: sampled with the operands.
  - 1 = operands and product are two's complement.
  - 0 = operands and product are unsigned.
- `i_w_start` in, 1: start request; accepted only in IDLE.
- `o_w_busy` out, 1: high while in RUN.
- `o_w_done` out, 1: one-cycle pulse; high exactly while in DONE.
- `o_w_out` out, 2W: product register; holds its value until the next DONE entry or reset.
- `o_w_disp_a` out, W: raw `i_w_a` captured at the last accepted start.
- `o_w_disp_b` out, W: raw `i_w_b` captured at the last accepted start.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - If `i_w_start`=1, load the operand registers and go to RUN.
  - Otherwise stay in IDLE.
- On accept:
  - `o_w_disp_a`/`o_w_disp_b` take the raw inputs.
  - The sign flag is set to `i_w_signed & (a[W-1] ^ b[W-1])`.
  - The 2W-bit multiplicand register takes |a|, zero-extended. In unsigned mode |a| = a.
  - The W-bit multiplier register takes |b|.
  - The accumulator clears to 0 and the iteration counter to 0.
- Magnitude of -2^(W-1) is 2^(W-1). It fits in W bits unsigned, so no overflow case exists.
- RUN, once per cycle:
  - If multiplier[0]=1, accumulator += multiplicand (mod 2^2W).
  - Multiplicand shifts left by 1; multiplier shifts right by 1; counter increments.
  - Exactly W iterations run, with no early termination.
- On the last (W-th) RUN edge:
  - `o_w_out` ← sign flag ? (−acc mod 2^2W) : acc. The value is computed with the final partial product included.
  - Go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- `i_w_start` in RUN or DONE is ignored. It is not queued, and operands and `o_w_disp_*` do not change.
- `i_w_signed` and the operand inputs may change freely after accept without affecting the operation in flight.
- Result range:
  - Unsigned: 0 … (2^W−1)².
  - Signed: −2^(W−1)(2^(W−1)−1) … 2^(2W−2).
  - Both ranges fit in 2W bits exactly.

## Timing
- Reset (`i_w_reset`=0 at a rising edge):
  - State returns to IDLE.
  - `o_w_busy`=0 and `o_w_done`=0.
  - `o_w_out`, `o_w_disp_a`, `o_w_disp_b`, accumulator and counter all become 0.
  - Reset has priority over start.
- Reset mid-RUN or in DONE aborts the operation: no done pulse, and `o_w_out` reads 0.
- Latency, with start accepted at edge E0:
  - `o_w_busy` is high for cycles E0+1 … E0+W.
  - `o_w_out` updates and `o_w_done` rises at edge E0+W.
  - `o_w_done` falls at edge E0+W+1, when the state returns to IDLE.
- The earliest next accept is at edge E0+W+2, i.e. a start held high from DONE is accepted in the following IDLE cycle. Throughput is one product per W+2 cycles.
- `o_w_busy` and `o_w_done` are Moore outputs decoded from registered state. They are never both high.
- `o_w_disp_*` update at E0.

## Test plan
- **Unsigned max, W=4:** a=0xF, b=0xF, signed=0, start one cycle.
  - busy high 4 cycles.
  - done pulse one cycle later with `o_w_out`=0xE1.
  - `o_w_disp_a`=0xF, `o_w_disp_b`=0xF.
- **Signed corners, W=4, signed=1:**
  - a=0x8, b=0x8 → 0x40.
  - a=0xD (−3), b=0x5 → 0xF1 (−15).
  - a=0x7, b=0x8 → 0xC8 (−56).
  - a=0x0, b=0x8 → 0x00.
- **Ignored start:** W=4, 3×5 accepted; pulse start with a=0x9, b=0x9 during RUN and during DONE.
  - `o_w_out`=0x0F and `o_w_disp_*` stay 3/5.
  - Exactly one done pulse.
  - The next op is accepted only in IDLE.
- **Reset mid-operation:** W=4, start 7×7, drive reset low on the 2nd RUN cycle.
  - Next cycle: all outputs 0, state IDLE, no done pulse.
  - After release, 2×3 → 0x06 with normal latency.
- **Back-to-back, W=8:** start held high continuously; a=0xFF, b=0xFF, unsigned, then a=0x80, b=0x80 signed.
  - 0xFE01 at done #1; 0x4000 at done #2.
  - Done pulses exactly W+2=10 cycles apart.
- **Result hold:** after done, idle 20 cycles with operand inputs toggling.
  - `o_w_out`, `o_w_disp_a`, `o_w_disp_b` unchanged.
  - busy=0, done=0.
